// File: rtl/mmio_store_port.sv
// MMIO register window feeding a 4-entry store FIFO; register reads are combinational, FIFO output lags a push by one cycle.
// Backpressure: out_ready stalls the head; a TXDATA store into a full FIFO without a same-cycle pop is dropped and flags overflow.
module mmio_store_port #(
    parameter logic [31:0] BASE  = 32'h0000_0080,
    parameter int          DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    input  logic        memwrite,
    output logic [31:0] readdata,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);
    localparam int             PW       = $clog2(DEPTH);
    localparam int             CW       = PW + 1;
    localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

    logic [31:0]    r_mem [DEPTH];
    logic [PW-1:0]  r_wptr;
    logic [PW-1:0]  r_rptr;
    logic [CW-1:0]  r_count;
    logic           r_ovf;
    logic [15:0]    r_storecnt;

    logic           w_hit;
    logic [1:0]     w_sel;
    logic           w_empty;
    logic           w_full;
    logic           w_push_req;
    logic           w_push;
    logic           w_pop;
    logic           w_ovf_set;
    logic           w_ctrl_wr;
    logic           w_ovf_clr;
    logic           w_flush;
    logic [31:0]    w_status;
    logic           w_unused;

    assign w_hit      = (dataadr[31:4] == BASE[31:4]);
    assign w_sel      = dataadr[3:2];
    assign w_unused   = ^dataadr[1:0];

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == FULL_CNT);
    assign w_pop      = !w_empty && out_ready;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push_req = memwrite && w_hit && (w_sel == 2'd0);
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_ovf_set  = w_push_req && w_full && !w_pop;

    assign w_ctrl_wr  = memwrite && w_hit && (w_sel == 2'd2);
    assign w_ovf_clr  = w_ctrl_wr && writedata[0];
    assign w_flush    = w_ctrl_wr && writedata[1];

    always_comb begin
        w_status      = '0;
        w_status[0]   = w_empty;
        w_status[1]   = w_full;
        w_status[2]   = r_ovf;
        w_status[6:4] = r_count;
    end

    always_comb begin
        readdata = '0;
        if (w_hit) begin
            case (w_sel)
                2'd1:    readdata = w_status;
                2'd3:    readdata = {16'h0000, r_storecnt};
                default: readdata = '0;
            endcase
        end
    end

    assign out_valid = !w_empty;
    assign out_data  = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= writedata;
        end
    end

    // Flush overrides any same-cycle pop; the popped word has already been taken by the consumer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
            r_storecnt <= '0;
        end else begin
            if (w_flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + PW'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + PW'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + CW'(1);
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - CW'(1);
                end
            end

            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end

            if (w_push) begin
                r_storecnt <= r_storecnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_mmio_store_port.sv
module tb_mmio_store_port;
    logic        clk;
    logic        reset;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic        memwrite;
    logic [31:0] readdata;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] rx[$];
    logic [31:0] v;

    mmio_store_port #(.BASE(32'h0000_0080), .DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .dataadr   (dataadr),
        .writedata (writedata),
        .memwrite  (memwrite),
        .readdata  (readdata),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Consumer model: record every word taken at a rising edge.
    always @(posedge clk) begin
        if (reset && out_valid && out_ready) begin
            rx.push_back(out_data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called just after a falling edge; holds the strobe across one rising edge.
    task automatic store(input logic [31:0] a, input logic [31:0] d);
        dataadr   = a;
        writedata = d;
        memwrite  = 1'b1;
        @(negedge clk);
        memwrite  = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] val);
        @(negedge clk);
        dataadr = a;
        #1;
        val = readdata;
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        out_ready = 1'b1;
        while (out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        if (cyc >= 20) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        dataadr = 32'h84;
        #2 reset = 1'b0;
        #1;
        chk("rst_async_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_async_status", readdata, 32'h01);
        #1 reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b0;
        dataadr   = 32'h84;
        writedata = '0;
        memwrite  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("reset_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_status", readdata, 32'h01);
        dataadr = 32'h8C;
        #1;
        chk("reset_storecnt", readdata, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Three queued words, consumer stalled
        store(32'h80, 32'h11);
        store(32'h80, 32'h22);
        store(32'h80, 32'h33);
        rd(32'h84, v); chk("st3_status", v, 32'h30);
        chk("st3_out_data", out_data, 32'h11);
        chk("st3_out_valid", {31'd0, out_valid}, 32'd1);
        rd(32'h87, v); chk("status_lowbits_ignored", v, 32'h30);
        rd(32'h80, v); chk("txdata_read_zero", v, 32'h0);
        rd(32'h88, v); chk("ctrl_read_zero", v, 32'h0);
        rd(32'h94, v); chk("nonhit_read_zero", v, 32'h0);

        // Fill then overflow
        store(32'h80, 32'h44);
        store(32'h80, 32'h55);
        rd(32'h84, v); chk("ovf_status", v, 32'h46);
        rd(32'h8C, v); chk("ovf_storecnt", v, 32'h4);
        chk("hold_out_data", out_data, 32'h11);
        store(32'h88, 32'h1);
        rd(32'h84, v); chk("ovf_cleared_status", v, 32'h42);

        // Full FIFO, simultaneous pop and push
        out_ready = 1'b1;
        store(32'h80, 32'hAA);
        out_ready = 1'b0;
        rd(32'h84, v); chk("full_pushpop_status", v, 32'h42);
        rd(32'h8C, v); chk("full_pushpop_storecnt", v, 32'h5);
        chk("full_pushpop_head", out_data, 32'h22);
        drain();
        chk("drain1_len", rx.size(), 32'd5);
        if (rx.size() == 5) begin
            chk("drain1_w0", rx[0], 32'h11);
            chk("drain1_w1", rx[1], 32'h22);
            chk("drain1_w2", rx[2], 32'h33);
            chk("drain1_w3", rx[3], 32'h44);
            chk("drain1_w4", rx[4], 32'hAA);
        end

        // Streaming with pointer wrap
        rx.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) store(32'h80, 32'hA + i);
        drain();
        chk("stream_len", rx.size(), 32'd6);
        for (int i = 0; i < 6 && i < rx.size(); i++) chk("stream_word", rx[i], 32'hA + i);
        rd(32'h84, v); chk("stream_status", v, 32'h01);
        rd(32'h8C, v); chk("stream_storecnt", v, 32'd11);

        // Flush with two queued words
        pulse_reset();
        store(32'h80, 32'h01);
        store(32'h80, 32'h02);
        store(32'h88, 32'h2);
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        rd(32'h84, v); chk("flush_status", v, 32'h01);
        rd(32'h8C, v); chk("flush_storecnt", v, 32'h2);

        // Flush in the same cycle as a pop
        store(32'h80, 32'h61);
        store(32'h80, 32'h62);
        rx.delete();
        out_ready = 1'b1;
        store(32'h88, 32'h2);
        out_ready = 1'b0;
        chk("flushpop_len", rx.size(), 32'd1);
        if (rx.size() == 1) chk("flushpop_word", rx[0], 32'h61);
        rd(32'h84, v); chk("flushpop_status", v, 32'h01);

        // Read-only registers ignore stores; non-hit stores ignored
        store(32'h84, 32'hFFFF_FFFF);
        store(32'h8C, 32'hFFFF_FFFF);
        store(32'h90, 32'h99);
        rd(32'h84, v); chk("ro_status", v, 32'h01);
        rd(32'h8C, v); chk("ro_storecnt", v, 32'h4);

        // Reset mid-operation discards queued words
        store(32'h80, 32'h71);
        store(32'h80, 32'h72);
        store(32'h80, 32'h73);
        pulse_reset();
        rd(32'h8C, v); chk("midrst_storecnt", v, 32'h0);
        store(32'h80, 32'h55);
        chk("midrst_valid", {31'd0, out_valid}, 32'd1);
        chk("midrst_out_data", out_data, 32'h55);
        rd(32'h8C, v); chk("midrst_storecnt1", v, 32'h1);
        rd(32'h84, v); chk("midrst_status", v, 32'h10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
